mnist_pool2x2: RTL and testbench
================================

# mnist_pool2x2

Downstream stage of the 14x14 binary image reader. Accepts one complete 196-bit binary image per handshake, scans it sequentially in 2x2 windows, and produces a 7x7 (49-bit) pooled feature map plus the total set-pixel count. These are the reduced inputs of the classifier stage. One window is processed per clock; results are held stable until the consumer accepts them.

## Interface

Parameters:
- POOL_THRESH, default 1: a pooled cell is 1 when its window's set-pixel count is >= POOL_THRESH. Legal range is 1..4.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: one clock; reset is synchronous and active-low.
- in_image, input, 196: binary image. Pixel (r,c) is at bit 195-(14*r+c), so row 0 occupies the MSBs and column 0 is the MSB within each row.
- in_valid, input, 1: in_image is valid.
- in_ready, output, 1: the block can accept an image.
- out_pool, output, 49: pooled map. Cell (i,j) is at bit 48-(7*i+j) and covers pixel rows 2i..2i+1 and columns 2j..2j+1.
- out_count, output, 8: total set pixels in the image, range 0..196.
- out_valid, output, 1: out_pool and out_count are valid.
- out_ready, input, 1: the consumer accepts the result.
- busy, output, 1: high in SCAN and DONE.

## Operation

- States are IDLE, SCAN and DONE.
- **IDLE**
  - in_ready=1.
  - On an edge with in_valid=1: latch in_image into an internal 196-bit register, clear the pool accumulator (49b) and count accumulator (8b), set win_row=0 and win_col=0, and go to SCAN.
- **SCAN**
  - in_ready=0. in_valid is ignored, and the latched image does not change.
  - On each edge, process window (win_row, win_col):
    - n = sum of the 4 pixels (3-bit, range 0..4).
    - Set the accumulator bit for cell (win_row, win_col) to (n >= POOL_THRESH).
    - Add n to the count accumulator. The 8-bit sum cannot overflow (maximum 196).
  - win_col increments 0..6. When it wraps to 0, win_row increments.
  - On the edge that processes window (6,6):
    - Load out_pool and out_count from the final accumulator values, including window (6,6).
    - Set out_valid=1.
    - Go to DONE.
- **DONE**
  - out_pool and out_count are held constant and in_ready=0.
  - On an edge with out_ready=1: out_valid goes to 0 and the state returns to IDLE.
- Outputs change only on entry to DONE. While idle or scanning, they keep the previous result.
- busy = (state != IDLE).
- Window counters never index past 6. An illegal state encoding recovers to IDLE.

## Timing

- Reset (reset_n=0 at an edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, out_pool=0, out_count=0.
  - Counters and accumulators are cleared.
  - Reset applies in any state, including mid-scan and in DONE with out_valid=1. Any partial result is discarded.
- in_ready and out_valid are registered. Neither depends combinationally on in_valid or out_ready.
- Let E0 be the edge where in_valid=1 while in IDLE:
  - Windows are processed on edges E1..E49, with window k=7i+j processed at edge E(k+1).
  - out_valid is high after E49, so latency is 49 cycles from acceptance.
- If out_ready=1 at the first DONE edge, out_valid is high for exactly 1 cycle. in_ready=1 in the following cycle.
- Back-to-back throughput is one image per 51 cycles: accept, 49 scan edges, release.
- Backpressure:
  - With out_ready=0, DONE is held indefinitely and the outputs are stable.
  - in_valid asserted during this time is not accepted, and the upstream must hold it.
- If in_valid and out_ready are both high in DONE, only the release happens. The new image is accepted on the next edge, from IDLE.

## Test plan

- All-zero image, POOL_THRESH=1: out_valid rises 49 cycles after acceptance; out_pool=0, out_count=0.
- All-ones image: out_pool=49'h1_FFFF_FFFF_FFFF, out_count=8'd196.
- Single pixel (0,0) set (in_image[195]=1):
  - POOL_THRESH=1: out_pool=49'h1_0000_0000_0000 (bit 48), out_count=1.
  - Same image, POOL_THRESH=2: out_pool=0, out_count=1.
- Checkerboard (pixel (r,c) set when r+c is even), POOL_THRESH=2 then 3:
  - POOL_THRESH=2: all 49 cells are 1.
  - POOL_THRESH=3: all cells are 0.
  - out_count=98 in both cases.
- Backpressure and ignore:
  - Hold out_ready=0 for 10 cycles in DONE: outputs do not change and in_ready stays 0.
  - A second image presented with in_valid=1 during SCAN is not captured.
  - After release, that image is accepted and its result is correct.
- Reset mid-scan: assert reset_n=0 at edge E20. Next cycle: in_ready=1, out_valid=0, outputs 0. A fresh image then completes normally.

Source files
------------

// File: rtl/mnist_pool2x2.sv
// 2x2 pooling stage for a 14x14 binary image: one window per clock, producing
// a 7x7 pooled map and the total set-pixel count with a valid/ready handshake.
module mnist_pool2x2 #(
    parameter int unsigned POOL_THRESH = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [195:0] in_image,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [48:0]  out_pool,
    output logic [7:0]   out_count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned IMG_W  = 196;
    localparam int unsigned POOL_W = 49;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WIN_W  = 3;
    localparam logic [WIN_W-1:0] WIN_LAST = 3'd6;
    localparam logic [2:0] THRESH = 3'(POOL_THRESH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state, state_d;
    logic [IMG_W-1:0]  img, img_d;
    logic [POOL_W-1:0] pool_acc, pool_acc_d;
    logic [CNT_W-1:0]  cnt_acc, cnt_acc_d;
    logic [WIN_W-1:0]  win_row, win_row_d;
    logic [WIN_W-1:0]  win_col, win_col_d;
    logic [POOL_W-1:0] out_pool_d;
    logic [CNT_W-1:0]  out_count_d;
    logic              out_valid_d;
    logic              in_ready_d;
    logic              busy_d;

    logic [7:0] base_idx;
    logic [5:0] cell_idx;
    logic [2:0] win_sum;

    // Pixel (2r,2c) sits at bit 195-(28r+2c); its 2x2 neighbours follow at -1, -14, -15.
    always_comb begin
        base_idx = 8'd195 - (8'd28 * 8'(win_row) + 8'd2 * 8'(win_col));
        cell_idx = 6'd48 - (6'd7 * 6'(win_row) + 6'(win_col));
        win_sum  = 3'(img[base_idx]) + 3'(img[base_idx - 8'd1])
                 + 3'(img[base_idx - 8'd14]) + 3'(img[base_idx - 8'd15]);
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            img       <= '0;
            pool_acc  <= '0;
            cnt_acc   <= '0;
            win_row   <= '0;
            win_col   <= '0;
            out_pool  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            img       <= img_d;
            pool_acc  <= pool_acc_d;
            cnt_acc   <= cnt_acc_d;
            win_row   <= win_row_d;
            win_col   <= win_col_d;
            out_pool  <= out_pool_d;
            out_count <= out_count_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state;
        img_d       = img;
        pool_acc_d  = pool_acc;
        cnt_acc_d   = cnt_acc;
        win_row_d   = win_row;
        win_col_d   = win_col;
        out_pool_d  = out_pool;
        out_count_d = out_count;
        out_valid_d = out_valid;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    img_d      = in_image;
                    pool_acc_d = '0;
                    cnt_acc_d  = '0;
                    win_row_d  = '0;
                    win_col_d  = '0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                pool_acc_d[cell_idx] = (win_sum >= THRESH);
                cnt_acc_d            = cnt_acc + CNT_W'(win_sum);
                if (win_col >= WIN_LAST) begin
                    win_col_d = '0;
                    if (win_row >= WIN_LAST) begin
                        // Final window: publish results including this window.
                        win_row_d   = '0;
                        out_pool_d  = pool_acc_d;
                        out_count_d = cnt_acc_d;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        win_row_d = win_row + WIN_W'(1);
                    end
                end else begin
                    win_col_d = win_col + WIN_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                win_row_d   = '0;
                win_col_d   = '0;
                state_d     = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mnist_pool2x2.sv
// Bench for mnist_pool2x2: three instances (thresholds 1,2,3) driven in lockstep,
// vector table plus handshake corner sequences, checked through a scoreboard queue.
module tb_mnist_pool2x2;

    typedef struct {
        logic [195:0] img;
        logic [48:0]  pool1;
        logic [48:0]  pool2;
        logic [48:0]  pool3;
        logic [7:0]   cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [195:0] in_image;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready1, in_ready2, in_ready3;
    logic         out_valid1, out_valid2, out_valid3;
    logic         busy1, busy2, busy3;
    logic [48:0]  pool1, pool2, pool3;
    logic [7:0]   cnt1, cnt2, cnt3;

    int checks = 0;
    int failures = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    mnist_pool2x2 #(.POOL_THRESH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_image(in_image), .in_valid(in_valid),
        .in_ready(in_ready1), .out_pool(pool1), .out_count(cnt1), .out_valid(out_valid1),
        .out_ready(out_ready), .busy(busy1));
    mnist_pool2x2 #(.POOL_THRESH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_image(in_image), .in_valid(in_valid),
        .in_ready(in_ready2), .out_pool(pool2), .out_count(cnt2), .out_valid(out_valid2),
        .out_ready(out_ready), .busy(busy2));
    mnist_pool2x2 #(.POOL_THRESH(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_image(in_image), .in_valid(in_valid),
        .in_ready(in_ready3), .out_pool(pool3), .out_count(cnt3), .out_valid(out_valid3),
        .out_ready(out_ready), .busy(busy3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pooling computed directly from pixel coordinates.
    function automatic vec_t model(input logic [195:0] img);
        vec_t v;
        int n;
        v.img = img; v.pool1 = '0; v.pool2 = '0; v.pool3 = '0; v.cnt = '0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                n = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        n += int'(img[195 - (14 * (2 * i + dr) + (2 * j + dc))]);
                v.pool1[48 - (7 * i + j)] = (n >= 1);
                v.pool2[48 - (7 * i + j)] = (n >= 2);
                v.pool3[48 - (7 * i + j)] = (n >= 3);
                v.cnt = v.cnt + 8'(n);
            end
        end
        return v;
    endfunction

    // Present an image at the next negedge once in_ready is seen; ends just after the accept edge.
    task automatic accept(input vec_t v);
        int t = 0;
        @(negedge clk);
        while (!in_ready1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 64'(in_ready1), 64'd1);
        in_image = v.img;
        in_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for the result, compare against the scoreboard, optionally hold off, then release.
    task automatic collect(input string tag, input int hold, input bit inject,
                           input logic [195:0] inj_img);
        int cyc = 0;
        vec_t e;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (inject && cyc == 5) begin
                in_image = inj_img;
                in_valid = 1'b1;
            end
            if (inject && cyc == 10) chk({tag, "_scan_in_ready"}, 64'(in_ready1), 64'd0);
        end while (!out_valid1 && cyc < 200);
        chk({tag, "_latency"}, 64'(cyc), 64'd49);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_pool_t1"}, 64'(pool1), 64'(e.pool1));
        chk({tag, "_pool_t2"}, 64'(pool2), 64'(e.pool2));
        chk({tag, "_pool_t3"}, 64'(pool3), 64'(e.pool3));
        chk({tag, "_count"}, 64'(cnt1), 64'(e.cnt));
        chk({tag, "_count_t3"}, 64'(cnt3), 64'(e.cnt));
        chk({tag, "_busy_done"}, 64'(busy1), 64'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid1), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(in_ready1), 64'd0);
            chk({tag, "_hold_pool"}, 64'(pool1), 64'(e.pool1));
            chk({tag, "_hold_count"}, 64'(cnt1), 64'(e.cnt));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_release_valid"}, 64'(out_valid1), 64'd0);
        chk({tag, "_release_in_ready"}, 64'(in_ready1), 64'd1);
        chk({tag, "_release_busy"}, 64'(busy1), 64'd0);
    endtask

    initial begin
        vec_t v, vb;
        logic [195:0] img;
        reset_n   = 1'b0;
        in_image  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        chk("rst_out_valid", 64'(out_valid1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_pool", 64'(pool1), 64'd0);
        chk("rst_count", 64'(cnt1), 64'd0);
        reset_n = 1'b1;

        // Hand-derived expectations for the directed images.
        tbl.push_back('{196'd0, 49'd0, 49'd0, 49'd0, 8'd0});
        img = '1;
        tbl.push_back('{img, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 8'd196});
        img = '0;
        img[195] = 1'b1;
        tbl.push_back('{img, 49'h1_0000_0000_0000, 49'd0, 49'd0, 8'd1});
        img = '0;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++)
                if ((r + c) % 2 == 0) img[195 - (14 * r + c)] = 1'b1;
        tbl.push_back('{img, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 49'd0, 8'd98});
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 7; w++) img[w * 28 +: 28] = 28'($urandom);
            tbl.push_back(model(img));
        end

        foreach (tbl[i]) begin
            accept(tbl[i]);
            collect($sformatf("vec%0d", i), 0, 1'b0, '0);
        end

        // Backpressure: hold DONE for 10 cycles.
        accept(tbl[2]);
        out_ready = 1'b0;
        collect("bp", 10, 1'b0, '0);

        // Image offered mid-scan is ignored, then accepted after release.
        for (int w = 0; w < 7; w++) img[w * 28 +: 28] = 28'($urandom);
        vb = model(img);
        accept(tbl[3]);
        out_ready = 1'b0;
        collect("ign", 3, 1'b1, vb.img);
        chk("ign_in_valid_held", 64'(in_valid), 64'd1);
        sb.push_back(vb);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect("ign_b", 0, 1'b0, '0);

        // Reset mid-scan at E20 discards the partial result.
        accept(tbl[1]);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready1), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid1), 64'd0);
        chk("mid_rst_busy", 64'(busy1), 64'd0);
        chk("mid_rst_pool", 64'(pool1), 64'd0);
        chk("mid_rst_count", 64'(cnt1), 64'd0);
        reset_n = 1'b1;
        void'(sb.pop_front());
        v = tbl[3];
        accept(v);
        collect("after_rst", 0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
